// File: rtl/ldpc_pkg.sv
// Shared types and defaults for the LDPC encoder controller slice.
`timescale 1ns/1ps
package ldpc_pkg;

    typedef enum logic [1:0] {
        ST_CFG    = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ENCODE = 2'd2,
        ST_OUTPUT = 2'd3
    } state_e;

    localparam int N_DEF       = 6;
    localparam int K_DEF       = 3;
    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/gf2_row_acc.sv
// N-bit GF(2) accumulator: synchronous clear, or XOR in one generator row.
`timescale 1ns/1ps
module gf2_row_acc #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [N-1:0] row,
    output logic [N-1:0] acc
);

    logic [N-1:0] acc_d;
    logic [N-1:0] acc_q;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q ^ row;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/encode_ctrl.sv
// Bit-serial LDPC encode sequencer: generator store, FSM and handshakes.
// Optional frame counter output enabled by ENCODE_CTRL_FRAME_CNT_EN.
`timescale 1ns/1ps
module encode_ctrl
    import ldpc_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int K = K_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    input  logic [N-1:0]           cfg_row,
    output logic                   cfg_done,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [K-1:0]           in_bits,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N-1:0]           out_codeword,
`ifdef ENCODE_CTRL_FRAME_CNT_EN
    output logic [FRAME_CNT_W-1:0] frame_cnt,
`endif
    output logic                   busy
);

    localparam int PW = (K > 1) ? $clog2(K) : 1;
    localparam logic [PW-1:0] LAST = PW'(K - 1);

    state_e          state_d, state_q;
    logic            cfg_done_d, cfg_done_q;
    logic [PW-1:0]   wr_ptr_d, wr_ptr_q;
    logic [PW-1:0]   bit_idx_d, bit_idx_q;
    logic [K-1:0]    frame_d, frame_q;
    logic [N-1:0]    g_d [K];
    logic [N-1:0]    g_q [K];
    logic            g_we;
    logic [PW-1:0]   g_idx;
    logic            acc_clr;
    logic            acc_en;
    logic [N-1:0]    acc;

    always_comb begin
        state_d    = state_q;
        cfg_done_d = cfg_done_q;
        wr_ptr_d   = wr_ptr_q;
        bit_idx_d  = bit_idx_q;
        frame_d    = frame_q;
        g_we       = 1'b0;
        g_idx      = wr_ptr_q;
        acc_clr    = 1'b0;
        unique case (state_q)
            ST_CFG: begin
                if (cfg_we) begin
                    g_we = 1'b1;
                    if (wr_ptr_q == LAST) begin
                        cfg_done_d = 1'b1;
                        wr_ptr_d   = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        wr_ptr_d = wr_ptr_q + PW'(1);
                    end
                end
            end
            ST_IDLE: begin
                // A frame always beats a simultaneous row write.
                if (in_valid) begin
                    frame_d   = in_bits;
                    acc_clr   = 1'b1;
                    bit_idx_d = '0;
                    state_d   = ST_ENCODE;
                end else if (cfg_we) begin
                    g_we  = 1'b1;
                    g_idx = '0;
                    if (K > 1) begin
                        cfg_done_d = 1'b0;
                        wr_ptr_d   = PW'(1);
                        state_d    = ST_CFG;
                    end
                end
            end
            ST_ENCODE: begin
                if (bit_idx_q == LAST) begin
                    bit_idx_d = '0;
                    state_d   = ST_OUTPUT;
                end else begin
                    bit_idx_d = bit_idx_q + PW'(1);
                end
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_CFG;
        endcase
    end

    always_comb begin
        g_d = g_q;
        if (g_we) begin
            g_d[g_idx] = cfg_row;
        end
    end

    assign acc_en = (state_q == ST_ENCODE) && frame_q[bit_idx_q];

    gf2_row_acc #(.N(N)) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .en    (acc_en),
        .row   (g_q[bit_idx_q]),
        .acc   (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CFG;
            cfg_done_q <= 1'b0;
            wr_ptr_q   <= '0;
            bit_idx_q  <= '0;
            frame_q    <= '0;
            for (int i = 0; i < K; i++) begin
                g_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cfg_done_q <= cfg_done_d;
            wr_ptr_q   <= wr_ptr_d;
            bit_idx_q  <= bit_idx_d;
            frame_q    <= frame_d;
            g_q        <= g_d;
        end
    end

    assign cfg_done     = cfg_done_q;
    assign in_ready     = (state_q == ST_IDLE);
    assign out_valid    = (state_q == ST_OUTPUT);
    assign busy         = (state_q == ST_ENCODE) || (state_q == ST_OUTPUT);
    assign out_codeword = acc;

`ifdef ENCODE_CTRL_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_d, frame_cnt_q;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (out_valid && out_ready) begin
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_encode_ctrl.sv
// Directed self-checking bench for encode_ctrl with N=6, K=3.
`timescale 1ns/1ps
module tb_encode_ctrl;

    localparam int N = 6;
    localparam int K = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_we;
    logic [N-1:0] cfg_row;
    logic         cfg_done;
    logic         in_valid;
    logic         in_ready;
    logic [K-1:0] in_bits;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_codeword;
    logic         busy;
`ifdef ENCODE_CTRL_FRAME_CNT_EN
    logic [15:0]  frame_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int hs_cyc = 0;
    int prev_hs;

    encode_ctrl #(.N(N), .K(K)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_we       (cfg_we),
        .cfg_row      (cfg_row),
        .cfg_done     (cfg_done),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_bits      (in_bits),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_codeword (out_codeword),
`ifdef ENCODE_CTRL_FRAME_CNT_EN
        .frame_cnt    (frame_cnt),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [N-1:0] row);
        cfg_we  = 1'b1;
        cfg_row = row;
        tick();
        cfg_we  = 1'b0;
    endtask

    task automatic load_default();
        cfg_write(6'b100110);
        cfg_write(6'b010011);
        check("cfg_done_pre", cfg_done, 0);
        cfg_write(6'b001101);
        check("cfg_done", cfg_done, 1);
        check("in_ready_cfg", in_ready, 1);
    endtask

    // Handshake at edge t, ENCODE over t+1..t+K, OUTPUT visible after t+K.
    task automatic send_frame(input string tag, input logic [K-1:0] bits,
                              input logic [N-1:0] exp, input int hold);
        in_valid  = 1'b1;
        in_bits   = bits;
        out_ready = (hold == 0);
        @(posedge clk);
        hs_cyc = cyc;
        #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_rdy0"}, in_ready, 0);
        repeat (K - 1) tick();
        check({tag, "_ov_early"}, out_valid, 0);
        tick();
        check({tag, "_ov"}, out_valid, 1);
        check({tag, "_cw"}, out_codeword, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_ov"}, out_valid, 1);
            check({tag, "_hold_cw"}, out_codeword, exp);
            check({tag, "_hold_rdy"}, in_ready, 0);
            check({tag, "_hold_busy"}, busy, 1);
        end
        out_ready = 1'b1;
        tick();
        check({tag, "_done_ov"}, out_valid, 0);
        check({tag, "_done_rdy"}, in_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_we    = 1'b0;
        cfg_row   = '0;
        in_valid  = 1'b0;
        in_bits   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cfg_done", cfg_done, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_codeword", out_codeword, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        check("cfg_in_ready", in_ready, 0);
        load_default();

        send_frame("f101", 3'b101, 6'b101011, 0);
        send_frame("f011", 3'b011, 6'b110101, 0);
        send_frame("bp", 3'b101, 6'b101011, 10);
        send_frame("f000", 3'b000, 6'b000000, 0);
        prev_hs = hs_cyc;
        send_frame("f111", 3'b111, 6'b111000, 0);
        check("throughput", hs_cyc - prev_hs, K + 2);
        prev_hs = hs_cyc;
        send_frame("f110", 3'b110, 6'b011110, 0);
        check("throughput2", hs_cyc - prev_hs, K + 2);

        cfg_we  = 1'b1;
        cfg_row = 6'b111111;
        send_frame("collide", 3'b001, 6'b100110, 0);
        check("collide_cfg_done", cfg_done, 1);
        send_frame("collide_g", 3'b001, 6'b100110, 0);

        cfg_write(6'b111111);
        check("reload_cfg_done", cfg_done, 0);
        check("reload_in_ready", in_ready, 0);
        cfg_write(6'b000000);
        cfg_write(6'b000000);
        check("reload_done", cfg_done, 1);
        send_frame("f100", 3'b100, 6'b000000, 0);
        send_frame("f001", 3'b001, 6'b111111, 0);
        send_frame("f111b", 3'b111, 6'b111111, 0);

        in_valid = 1'b1;
        in_bits  = 3'b111;
        tick();
        in_valid = 1'b0;
        tick();
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_out_valid", out_valid, 0);
        check("mid_cfg_done", cfg_done, 0);
        check("mid_busy_rst", busy, 0);
        check("mid_codeword", out_codeword, 0);
`ifdef ENCODE_CTRL_FRAME_CNT_EN
        check("cnt_rst", frame_cnt, 0);
`endif
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_bits  = 3'b101;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("norel_rdy", in_ready, 0);
            check("norel_busy", busy, 0);
            check("norel_ov", out_valid, 0);
        end
        in_valid = 1'b0;
        load_default();
        send_frame("post_rst", 3'b010, 6'b010011, 0);
        send_frame("post_rst2", 3'b101, 6'b101011, 0);
`ifdef ENCODE_CTRL_FRAME_CNT_EN
        check("cnt_two", frame_cnt, 2);
        cfg_write(6'b100110);
        cfg_write(6'b010011);
        cfg_write(6'b001101);
        check("cnt_keep", frame_cnt, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
